// File: rtl/spi_pkg.sv
// SPI transaction sequencer shared types and default timing constants.
// States, setup/hold lengths and per-byte watchdog limit.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    START,
    XFER,
    HOLD,
    ERR
  } spi_seq_state_t;

  localparam int SETUP_CYC   = 2;
  localparam int HOLD_CYC    = 2;
  localparam int TIMEOUT_CYC = 1024;

endpackage

// File: rtl/spi_sel_dec.sv
// Registered index-to-one-hot slave select decoder with enable.
// Ports: clk, rst (async high), en, idx in; sel one-hot out (0 when !en).
module spi_sel_dec #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [SW-1:0] idx,
  output logic [N-1:0]  sel
);

  logic [N-1:0] sel_d;

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < N; i++) begin
      sel_d[i] = en && (idx == SW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
    end else begin
      sel <= sel_d;
    end
  end

endmodule

// File: rtl/spi_seq.sv
// SPI transaction sequencer: request -> select setup -> per-byte load/start/xfer -> hold.
// Ports: req_*, tx_* stream in, rx_* stream out, done/err pulses, sel, spi master start/status.
module spi_seq #(
  parameter int NSLAVE      = 2,
  parameter int SETUP_CYC   = spi_pkg::SETUP_CYC,
  parameter int HOLD_CYC    = spi_pkg::HOLD_CYC,
  parameter int TIMEOUT_CYC = spi_pkg::TIMEOUT_CYC,
  localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SW-1:0]     req_slave,
  input  logic [3:0]        req_len,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              done,
  output logic              err,
  output logic [NSLAVE-1:0] sel,
  output logic              spi_start,
  output logic [7:0]        spi_data_in,
  input  logic              spi_busy,
  input  logic              spi_new_data,
  input  logic [7:0]        spi_data_out
);

  import spi_pkg::*;

  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW:0]    NS_MAX     = (SW + 1)'(NSLAVE);
  localparam logic [7:0]     SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0]     HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [WW-1:0]  WD_LAST    = WW'(TIMEOUT_CYC - 1);

  spi_seq_state_t state;
  logic [SW-1:0]  slave_q;
  logic [3:0]     rem;
  logic [7:0]     cnt;
  logic [WW-1:0]  wdog;

  logic           accept;
  logic           slave_ok;
  logic           setup_last;
  logic           hold_last;
  logic           tmo;
  logic [3:0]     rem_next;
  logic           sel_en;
  logic [SW-1:0]  sel_idx;

  assign accept     = req_valid && req_ready;
  assign slave_ok   = {1'b0, req_slave} < NS_MAX;
  assign setup_last = (cnt == SETUP_LAST);
  assign hold_last  = (cnt == HOLD_LAST);
  assign tmo        = !spi_new_data && (wdog == WD_LAST);
  assign rem_next   = rem - 4'd1;

  // Select enable is the next-state view of "sel held", so the
  // registered decoder raises sel at acceptance+1 and drops it
  // on the same edge that issues done or the timeout err.
  always_comb begin
    sel_en  = 1'b0;
    sel_idx = slave_q;
    unique case (state)
      IDLE: begin
        sel_en  = accept && slave_ok && (req_len != 4'd0);
        sel_idx = req_slave;
      end
      SETUP, LOAD, START: sel_en = 1'b1;
      XFER:    sel_en = !tmo;
      HOLD:    sel_en = !hold_last;
      default: sel_en = 1'b0;
    endcase
  end

  spi_sel_dec #(
    .N  (NSLAVE),
    .SW (SW)
  ) u_sel_dec (
    .clk (clk),
    .rst (rst),
    .en  (sel_en),
    .idx (sel_idx),
    .sel (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slave_q     <= '0;
      rem         <= '0;
      cnt         <= '0;
      wdog        <= '0;
      req_ready   <= 1'b0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
    end else begin
      spi_start <= 1'b0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            slave_q <= req_slave;
            rem     <= req_len;
            cnt     <= '0;
            if (!slave_ok) begin
              state     <= ERR;
              err       <= 1'b1;
              req_ready <= 1'b0;
            end else if (req_len == 4'd0) begin
              done <= 1'b1;
            end else begin
              state     <= SETUP;
              req_ready <= 1'b0;
            end
          end
        end
        SETUP: begin
          if (setup_last) begin
            cnt      <= '0;
            state    <= LOAD;
            tx_ready <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LOAD: begin
          if (tx_valid) begin
            spi_data_in <= tx_data;
            tx_ready    <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          if (!spi_busy) begin
            spi_start <= 1'b1;
            wdog      <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (spi_new_data) begin
            rx_data  <= spi_data_out;
            rx_valid <= 1'b1;
            rem      <= rem_next;
            if (rem_next != 4'd0) begin
              state    <= LOAD;
              tx_ready <= 1'b1;
            end else begin
              state <= HOLD;
              cnt   <= '0;
            end
          end else if (tmo) begin
            err       <= 1'b1;
            rem       <= '0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        HOLD: begin
          if (hold_last) begin
            cnt       <= '0;
            done      <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_seq.sv
// Self-checking bench for spi_seq: vector table plus timing,
// busy-wait, watchdog and mid-transfer reset sequences.
module tb_spi_seq;

  localparam int NS = 3;
  localparam int SW = 2;
  localparam int SC = 2;
  localparam int HC = 2;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_slave;
  logic [3:0]    req_len;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          done;
  logic          err;
  logic [NS-1:0] sel;
  logic          spi_start;
  logic [7:0]    spi_data_in;
  logic          spi_busy;
  logic          spi_new_data;
  logic [7:0]    spi_data_out;

  always #5 clk = ~clk;

  spi_seq #(
    .NSLAVE      (NS),
    .SETUP_CYC   (SC),
    .HOLD_CYC    (HC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_slave    (req_slave),
    .req_len      (req_len),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .done         (done),
    .err          (err),
    .sel          (sel),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data),
    .spi_data_out (spi_data_out)
  );

  typedef struct {
    int            slave;
    int            len;
    int            tx_base;
    int            resp;
    int            resp_step;
    int            exp_done;
    int            exp_err;
    int            exp_starts;
    logic [NS-1:0] exp_sel;
  } vec_t;

  vec_t vecs[6];

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int n_start, n_done, n_err, n_rx;
  int onehot_bad = 0;
  int busy_bad = 0;
  int both_bad = 0;
  int start_cyc, done_cyc, err_cyc, rx_cyc;
  int sel_rise, sel_fall, txr_cyc;
  logic [NS-1:0] sel_seen;
  logic [NS-1:0] sel_prev = '0;
  logic busy_prev = 1'b0;

  logic [7:0] tx_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] txs_log[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  bit slave_en = 1'b1;
  int busy_extra = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (spi_start) begin
        n_start++;
        start_cyc = cyc;
        if (busy_prev) busy_bad++;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; end
      if (done && err) both_bad++;
      if (rx_valid) begin
        n_rx++;
        rx_cyc = cyc;
        rx_log.push_back(rx_data);
      end
      if ($countones(sel) > 1) onehot_bad++;
      sel_seen = sel_seen | sel;
      if (sel != '0 && sel_prev == '0) sel_rise = cyc;
      if (sel == '0 && sel_prev != '0) sel_fall = cyc;
      if (tx_ready && txr_cyc < 0) txr_cyc = cyc;
    end
    sel_prev  = sel;
    busy_prev = spi_busy;
  end

  // Write-byte source.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(posedge clk);
      if (tx_valid && tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
      #1;
      tx_valid = (tx_q.size() > 0);
      tx_data  = tx_valid ? tx_q[0] : 8'h00;
    end
  end

  // SPI master model: busy for a few cycles, then returns a byte.
  initial begin
    spi_busy     = 1'b0;
    spi_new_data = 1'b0;
    spi_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spi_start && slave_en && !rst) begin
        txs_log.push_back(spi_data_in);
        spi_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (resp_q.size() > 0) spi_data_out = resp_q.pop_front();
        else spi_data_out = 8'h00;
        spi_new_data = 1'b1;
        @(posedge clk);
        #1;
        spi_new_data = 1'b0;
        for (int k = 0; k < busy_extra; k++) begin
          @(posedge clk);
          #1;
        end
        spi_busy = 1'b0;
      end
    end
  end

  task automatic clear_obs();
    tx_q.delete();
    resp_q.delete();
    rx_log.delete();
    txs_log.delete();
    exp_tx.delete();
    exp_rx.delete();
    n_start  = 0;
    n_done   = 0;
    n_err    = 0;
    n_rx     = 0;
    sel_seen = '0;
    start_cyc = -1;
    done_cyc = -1;
    err_cyc  = -1;
    rx_cyc   = -1;
    sel_rise = -1;
    sel_fall = -1;
    txr_cyc  = -1;
  endtask

  task automatic send_req(input int s, input int l, output int acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_slave = SW'(s);
    req_len   = 4'(l);
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    #1;
    req_valid = 1'b0;
    if (acc < 0) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_end(input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (n_done + n_err > 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("end_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, output int acc);
    @(posedge clk);
    #2;
    clear_obs();
    for (int b = 0; b < v.len; b++) begin
      tx_q.push_back(8'(v.tx_base * (b + 1)));
      resp_q.push_back(8'(v.resp + b * v.resp_step));
      exp_tx.push_back(8'(v.tx_base * (b + 1)));
      exp_rx.push_back(8'(v.resp + b * v.resp_step));
    end
    send_req(v.slave, v.len, acc);
    wait_end(v.len * 30 + TO + 50);
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic check_vec(input string p, input vec_t v);
    int mism;
    check({p, "_done"}, n_done, v.exp_done);
    check({p, "_err"}, n_err, v.exp_err);
    check({p, "_starts"}, n_start, v.exp_starts);
    check({p, "_sel"}, sel_seen, v.exp_sel);
    check({p, "_rx_cnt"}, n_rx, v.exp_starts);
    mism = 0;
    for (int b = 0; b < rx_log.size() && b < exp_rx.size(); b++)
      if (rx_log[b] !== exp_rx[b]) mism++;
    check({p, "_rx_data_mism"}, mism, 0);
    mism = 0;
    if (txs_log.size() != v.exp_starts) mism++;
    for (int b = 0; b < txs_log.size() && b < exp_tx.size(); b++)
      if (txs_log[b] !== exp_tx[b]) mism++;
    check({p, "_tx_data_mism"}, mism, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int acc;
    vec_t v;
    vecs[0] = '{0, 1,  'hA5, 'hAA, 0, 1, 0, 1,  3'b001};
    vecs[1] = '{1, 3,  'h11, 'h55, 0, 1, 0, 3,  3'b010};
    vecs[2] = '{0, 0,  'h00, 'h00, 0, 1, 0, 0,  3'b000};
    vecs[3] = '{3, 2,  'h10, 'h20, 0, 0, 1, 0,  3'b000};
    vecs[4] = '{2, 2,  'hC3, 'h0F, 1, 1, 0, 2,  3'b100};
    vecs[5] = '{1, 15, 'h07, 'hE0, 3, 1, 0, 15, 3'b010};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_slave = '0;
    req_len   = '0;
    clear_obs();
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_sel", sel, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_outs", {spi_start, rx_valid, done, err}, 0);
    check("rst_data", {rx_data, spi_data_in}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_release_req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], acc);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Single byte timing: select setup, load point, hold length.
    v = '{2, 1, 'h3C, 'h81, 0, 1, 0, 1, 3'b100};
    run_vec(v, acc);
    check_vec("t1", v);
    check("t1_sel_rise", sel_rise - acc, 1);
    check("t1_tx_ready_at", txr_cyc - acc, 1 + SC);
    check("t1_hold_len", done_cyc - rx_cyc, HC);
    check("t1_sel_fall", sel_fall, done_cyc);

    // Zero length: done right after acceptance.
    v = '{1, 0, 'h00, 'h00, 0, 1, 0, 0, 3'b000};
    run_vec(v, acc);
    check("z_done_at", done_cyc - acc, 1);
    check("z_starts", n_start, 0);
    check("z_sel", sel_seen, 0);

    // Master stays busy: second start must wait.
    busy_extra = 4;
    v = '{0, 2, 'h5A, 'h99, 1, 1, 0, 2, 3'b001};
    run_vec(v, acc);
    check_vec("bz", v);
    busy_extra = 0;

    // Watchdog: master never answers.
    slave_en = 1'b0;
    @(posedge clk);
    #2;
    clear_obs();
    for (int b = 0; b < 3; b++) tx_q.push_back(8'(8'h40 + b));
    send_req(1, 3, acc);
    wait_end(TO + 80);
    check("to_err", n_err, 1);
    check("to_done", n_done, 0);
    check("to_err_at", err_cyc - start_cyc, TO);
    check("to_sel_at_err", sel, 0);
    @(negedge clk);
    #1;
    check("to_req_ready_next", req_ready, 1);
    repeat (10) @(negedge clk);
    #1;
    check("to_starts", n_start, 1);
    check("to_rx", n_rx, 0);
    slave_en = 1'b1;

    // Reset in the middle of a 4-byte transfer.
    @(posedge clk);
    #2;
    clear_obs();
    for (int b = 0; b < 4; b++) begin
      tx_q.push_back(8'(8'h60 + b));
      resp_q.push_back(8'(8'h70 + b));
    end
    send_req(2, 4, acc);
    for (int k = 0; k < 200 && n_start < 2; k++) @(negedge clk);
    @(posedge clk);
    #2;
    check("rr_sel_before", sel, 3'b100);
    rst = 1'b1;
    #1;
    check("rr_sel_async", sel, 0);
    check("rr_req_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    check("rr_no_pulse", n_done + n_err, 0);
    tx_q.delete();
    resp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rr_req_ready_after", req_ready, 1);
    repeat (10) @(negedge clk);
    v = '{0, 1, 'hE7, 'h42, 0, 1, 0, 1, 3'b001};
    run_vec(v, acc);
    check_vec("rr", v);

    check("onehot_violations", onehot_bad, 0);
    check("start_while_busy", busy_bad, 0);
    check("done_err_same_cycle", both_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_seq.md
SPI_SEQ -- requirements
Module: spi_seq

Interface
REQ-001 Parameter NSLAVE, default 2: number of slave selects driven.
REQ-002 Parameter SETUP_CYC, default 2: clk cycles sel is held before the first byte starts.
REQ-003 Parameter HOLD_CYC, default 2: clk cycles sel is held after the last byte completes.
REQ-004 Parameter TIMEOUT_CYC, default 1024: maximum clk cycles allowed per byte in XFER.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 req_valid  in  1  transaction request.
REQ-008 req_ready  out  1  high only in IDLE.
REQ-009 req_slave  in  $clog2(NSLAVE) (min 1)  target slave index.
REQ-010 req_len  in  4  byte count, 0..15.
REQ-011 tx_valid / tx_ready / tx_data  in / out / in  1/1/8  write-byte stream, valid-ready handshake.
REQ-012 rx_valid / rx_data  out / out  1/8  read-byte stream; no backpressure.
REQ-013 done / err  out / out  1/1  one-cycle completion and error pulses.
REQ-014 sel  out  NSLAVE  one-hot slave select, active high, to the slave mux and the SPI master start logic.
REQ-015 spi_start / spi_data_in  out / out  1/8  SPI master start pulse and byte to send.
REQ-016 spi_busy / spi_new_data / spi_data_out  in / in / in  1/1/8  SPI master status and received byte.

Function
REQ-017 States SHALL be IDLE, SETUP, LOAD, START, XFER, HOLD, ERR.
REQ-018 A request SHALL be accepted in the cycle where req_valid && req_ready; slave and length are latched in that cycle.
REQ-019 If req_len==0, the block SHALL pulse done in the next cycle, assert no sel, and return to IDLE.
REQ-020 If req_slave>=NSLAVE, the block SHALL go to ERR, pulse err for one cycle, assert no sel, and return to IDLE.
REQ-021 SETUP: sel[req_slave] SHALL be high from acceptance+1 and stay high through HOLD; exactly SETUP_CYC cycles are spent in SETUP, then the block enters LOAD.
REQ-022 LOAD: tx_ready SHALL be high only in this state; on tx_valid the byte is registered into spi_data_in and the block enters START.
REQ-023 START: spi_start SHALL pulse for exactly one cycle, and only when spi_busy is low; otherwise the block waits in START. The block then enters XFER.
REQ-024 XFER: on spi_new_data, spi_data_out SHALL be registered to rx_data and rx_valid pulsed the next cycle.
REQ-025 XFER, remaining count: the 4-bit counter SHALL decrement; nonzero -> LOAD, zero -> HOLD.
REQ-026 HOLD: after HOLD_CYC cycles, sel SHALL drop, done SHALL pulse in the same cycle, and the block enters IDLE.
REQ-027 Timeout: the watchdog SHALL be cleared on XFER entry; when it reaches TIMEOUT_CYC without spi_new_data, sel drops, err pulses, and the block enters IDLE; remaining bytes are discarded.
REQ-028 At most one sel bit SHALL be high at any time, and sel SHALL never change while in XFER.
REQ-029 spi_data_in SHALL hold its value from LOAD through the end of XFER.
REQ-030 done and err SHALL never pulse in the same cycle.

Reset
REQ-031 While rst is high, the state SHALL be IDLE, sel=0, spi_start=0, tx_ready=0, rx_valid=0, done=0, err=0, rx_data=0, spi_data_in=0, all counters 0, and req_ready=0.
REQ-032 Reset mid-transaction SHALL drop sel immediately (asynchronously); no done or err pulse is issued; req_ready rises in the first cycle after rst falls.

Structure
REQ-033 Package spi_pkg SHALL hold the state enum (spi_seq_state_t) and the default constants SETUP_CYC, HOLD_CYC, and TIMEOUT_CYC.
REQ-034 There SHALL be one sub-module, spi_sel_dec: registered index-to-one-hot decoder with enable; timeout and byte counters stay inline.

Verification
REQ-035 Scenario: req slave 0, len 1, tx 0xA5; slave returns 0xAA -> sel=2'b01, one spi_start, rx_data=0xAA, done once, sel low after HOLD_CYC.
REQ-036 Scenario: req slave 1, len 3, tx 0x11/0x22/0x33; slave returns 0x55 each byte -> three rx_valid pulses of 0x55, sel=2'b10 held throughout, one done.
REQ-037 Scenario: req_len=0 -> done at acceptance+1, sel never asserted, no spi_start.
REQ-038 Scenario: req_slave=2 with NSLAVE=2 -> err pulse, no sel, no done.
REQ-039 Scenario: spi_new_data held low after start -> err exactly TIMEOUT_CYC cycles after XFER entry, sel low, req_ready high the next cycle.
REQ-040 Scenario: rst asserted mid-XFER of a len-4 request -> sel=0 with no clk edge, no done or err, and a new request completes normally afterwards.
